// File: rtl/axis_fifo_arbiter.sv
// Round-robin arbiter that shares the fifo write port among NREQ AXI-Stream
// slave channels; a grant ends on tlast or after MAX_BURST beats.
module axis_fifo_arbiter #(
  parameter int NREQ      = 2,
  parameter int DWIDTH    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ*DWIDTH-1:0] s_tdata,
  input  logic [NREQ-1:0]        s_tvalid,
  input  logic [NREQ-1:0]        s_tlast,
  output logic [NREQ-1:0]        s_tready,
  output logic [DWIDTH-1:0]      fifo_wdata,
  output logic                   fifo_wren,
  input  logic                   fifo_full,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic [0:0]             fsm_state
);

  // Handshake: a beat moves on any rising edge where s_tvalid[g] and
  // s_tready[g] are both high; s_tready is only ever raised for the owner.
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_BURST - 1);

  logic [0:0]        state;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     last_owner;
  logic [CW-1:0]     beat_cnt;
  logic [IW-1:0]     cand;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;
  logic [NREQ-1:0]   pick_onehot;
  logic [DWIDTH-1:0] owner_data;
  logic              beat;
  logic              rel;

  // Loop runs from the farthest candidate down so the nearest requester
  // after last_owner is the one left in pick_idx.
  always_comb begin
    pick_valid  = 1'b0;
    pick_idx    = '0;
    cand        = '0;
    pick_onehot = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last_owner) + k) % NREQ);
      if (s_tvalid[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_onehot[pick_idx] = 1'b1;
  end

  always_comb begin
    s_tready   = '0;
    owner_data = s_tdata[int'(owner)*DWIDTH +: DWIDTH];
    beat       = (state == GRANT) & ~fifo_full & s_tvalid[owner];
    rel        = beat & (s_tlast[owner] | (beat_cnt == CNT_LAST));
    if (state == GRANT && !fifo_full) s_tready[owner] = 1'b1;
    fifo_wren  = beat;
    fifo_wdata = beat ? owner_data : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      beat_cnt   <= '0;
      last_owner <= LAST_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= GRANT;
            grant    <= pick_onehot;
            owner    <= pick_idx;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            state      <= IDLE;
            grant      <= '0;
            beat_cnt   <= '0;
            last_owner <= owner;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  assign busy      = (state == GRANT);
  assign fsm_state = state;

endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// Randomized bench for axis_fifo_arbiter: per-channel packet sources, a
// cycle-level integer model of the round-robin rules, and a write scoreboard.
module tb_axis_fifo_arbiter;

  localparam int NREQ      = 2;
  localparam int DWIDTH    = 8;
  localparam int MAX_BURST = 16;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [NREQ*DWIDTH-1:0] s_tdata;
  logic [NREQ-1:0]        s_tvalid;
  logic [NREQ-1:0]        s_tlast;
  logic [NREQ-1:0]        s_tready;
  logic [DWIDTH-1:0]      fifo_wdata;
  logic                   fifo_wren;
  logic                   fifo_full;
  logic [NREQ-1:0]        grant;
  logic                   busy;
  logic [0:0]             fsm_state;

  axis_fifo_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rstn(rstn), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready), .fifo_wdata(fifo_wdata),
    .fifo_wren(fifo_wren), .fifo_full(fifo_full), .grant(grant),
    .busy(busy), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // sources: {tlast, tdata}
  logic [DWIDTH:0]   src0_q[$];
  logic [DWIDTH:0]   src1_q[$];
  logic [DWIDTH-1:0] exp_q[$];

  int m_owner;
  int m_last;
  int m_cnt;
  int vprob;
  int fprob;
  bit force_full;
  logic [NREQ-1:0] hs_prev;

  function automatic int q_size(input int ch);
    return (ch == 0) ? src0_q.size() : src1_q.size();
  endfunction

  function automatic logic [DWIDTH:0] q_head(input int ch);
    return (ch == 0) ? src0_q[0] : src1_q[0];
  endfunction

  task automatic q_push(input int ch, input logic [DWIDTH:0] v);
    if (ch == 0) src0_q.push_back(v);
    else src1_q.push_back(v);
  endtask

  task automatic q_pop(input int ch);
    if (ch == 0) void'(src0_q.pop_front());
    else void'(src1_q.pop_front());
  endtask

  task automatic add_packet(input int ch, input int len, input int base);
    for (int i = 0; i < len; i++)
      q_push(ch, {(i == len - 1), DWIDTH'(base + i)});
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
    m_cnt   = 0;
  endtask

  task automatic clear_all();
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    s_tvalid   = '0;
    s_tlast    = '0;
    s_tdata    = '0;
    fifo_full  = 1'b0;
    force_full = 1'b0;
    hs_prev    = '0;
    model_reset();
  endtask

  // driver + model + scoreboard for one clock cycle (entered at posedge+1)
  task automatic step();
    logic [DWIDTH:0]   head;
    logic [NREQ-1:0]   exp_ready;
    logic [NREQ-1:0]   exp_grant;
    logic              exp_beat;
    logic [DWIDTH-1:0] exp_data;
    bit                was_idle;
    for (int ch = 0; ch < NREQ; ch++) begin
      if (hs_prev[ch]) begin
        q_pop(ch);
        s_tvalid[ch] = 1'b0;
      end
      if (!s_tvalid[ch]) begin
        s_tdata[ch*DWIDTH +: DWIDTH] = DWIDTH'($urandom);
        s_tlast[ch] = 1'($urandom);
        if (q_size(ch) > 0 && $urandom_range(0, 99) < vprob) begin
          head = q_head(ch);
          s_tvalid[ch] = 1'b1;
          s_tdata[ch*DWIDTH +: DWIDTH] = head[DWIDTH-1:0];
          s_tlast[ch] = head[DWIDTH];
        end
      end
    end
    fifo_full = force_full || ($urandom_range(0, 99) < fprob);

    @(negedge clk);
    exp_grant = (m_owner < 0) ? '0 : NREQ'(1 << m_owner);
    exp_ready = (m_owner >= 0 && !fifo_full) ? exp_grant : '0;
    exp_beat  = (exp_ready & s_tvalid) != '0;
    exp_data  = DWIDTH'(s_tdata >> (DWIDTH * ((m_owner < 0) ? 0 : m_owner)));
    check("grant", grant, exp_grant);
    check("busy", busy, (m_owner >= 0));
    check("s_tready", s_tready, exp_ready);
    check("fifo_wren", fifo_wren, exp_beat);

    was_idle = (m_owner < 0);
    if (was_idle) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (m_owner < 0 && s_tvalid[(m_last + k) % NREQ]) begin
          m_owner = (m_last + k) % NREQ;
          m_cnt   = 0;
        end
      end
    end else if (exp_beat) begin
      exp_q.push_back(exp_data);
      m_cnt++;
      if (((s_tlast >> m_owner) & 1) != 0 || m_cnt == MAX_BURST) begin
        m_last  = m_owner;
        m_owner = -1;
        m_cnt   = 0;
      end
    end

    if (fifo_wren === 1'b1) begin
      check("wr_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("wdata", fifo_wdata, exp_q.pop_front());
    end
    hs_prev = s_tvalid & s_tready;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (n < limit && !(src0_q.size() == 0 && src1_q.size() == 0 && hs_prev == '0 &&
                          s_tvalid == '0 && m_owner < 0 && exp_q.size() == 0)) begin
      step();
      n++;
    end
    check("drain_pending", src0_q.size() + src1_q.size() + exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_s_tready"}, s_tready, 0);
    check({tag, "_fifo_wren"}, fifo_wren, 0);
    check({tag, "_wdata_known"}, $isunknown(fifo_wdata), 0);
  endtask

  initial begin
    rstn = 1'b0;
    clear_all();
    vprob = 100;
    fprob = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // single 3-beat packet on ch0
    q_push(0, {1'b0, 8'h11});
    q_push(0, {1'b0, 8'h22});
    q_push(0, {1'b1, 8'h33});
    drain(50);

    // both channels, two 2-beat packets each, alternating grants
    add_packet(0, 2, 8'h40);
    add_packet(1, 2, 8'h50);
    add_packet(0, 2, 8'h60);
    add_packet(1, 2, 8'h70);
    drain(100);

    // long ch0 stream forced to release at MAX_BURST while ch1 waits
    add_packet(0, 40, 8'h00);
    add_packet(1, 3, 8'h80);
    drain(300);

    // fifo_full held for 5 cycles in the middle of a packet
    add_packet(0, 10, 8'h90);
    repeat (4) step();
    force_full = 1'b1;
    repeat (5) step();
    force_full = 1'b0;
    drain(100);

    // tlast on the MAX_BURST-th beat releases once
    add_packet(0, 16, 8'hA0);
    add_packet(0, 17, 8'hB0);
    add_packet(1, 2, 8'hC0);
    drain(300);

    // reset in the middle of a ch1 burst
    add_packet(1, 20, 8'hD0);
    repeat (6) step();
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    clear_all();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    add_packet(1, 3, 8'hE0);
    add_packet(0, 3, 8'hF0);
    drain(100);

    // randomized traffic with gaps and backpressure
    for (int r = 0; r < 8; r++) begin
      vprob = $urandom_range(40, 100);
      fprob = $urandom_range(0, 40);
      for (int p = 0; p < 6; p++)
        add_packet($urandom_range(0, NREQ - 1), $urandom_range(1, 20), $urandom_range(0, 255));
      drain(3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
